// File: rtl/uart_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_if
//   Bundles the write, read, status and error signals of the UART receive
//   FIFO.
//
//   Modports
//     master : producer/consumer side. It drives wr_en, wr_data, rd_en and
//              clr_err, and observes everything else.
//     slave  : the FIFO itself.
//
//   Signals
//     wr_en / wr_data      byte strobe from the receiver (end-of-frame pulse)
//     rd_en                pop request from host/DMA
//     rd_data / rd_valid   read data and its qualifier
//     empty / full         occupancy boundaries
//     almost_full          count >= AFULL_LVL
//     count                occupancy, 0..DEPTH
//     overrun / underrun   sticky error flags
//     clr_err              synchronous clear of both error flags
//
//   DATA_W and ADDR_W must match the parameters of the attached FIFO.
// ----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic              underrun;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, empty, full, almost_full, count,
             overrun, underrun
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, empty, full, almost_full, count,
             overrun, underrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer placed directly after the UART receiver. Each
//   byte is captured on the receiver's end-of-frame strobe. The FIFO holds up
//   to DEPTH bytes for the host/DMA side and reports occupancy, almost-full
//   and sticky overrun/underrun errors.
//
//   Ports
//     clk_r   receive-domain clock, rising edge
//     rst_n   asynchronous reset, active-low
//     bus     uart_rx_fifo_if.slave (write/read/status/error signals)
//
//   Build option
//     UART_RX_FIFO_FWFT_EN  defined   : first-word-fall-through. The head
//                                       word is always on rd_data, and
//                                       rd_valid = ~empty.
//                           undefined : standard mode. rd_data is registered
//                                       on a pop, and rd_valid pulses for
//                                       one cycle.
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int DEPTH     = 16,   // must equal 2**ADDR_W
   parameter int AFULL_LVL = 12
) (
   input  logic            clk_r,
   input  logic            rst_n,
   uart_rx_fifo_if.slave   bus
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count_q, count_nxt;
   logic              empty_q, full_q, afull_q;
   logic              overrun_q, underrun_q;
   logic              rd_acc, wr_acc;

   // When full, a write is still taken if a read frees a slot on the same
   // edge. When empty, a read is never taken, even if a write arrives.
   assign rd_acc = bus.rd_en & ~empty_q;
   assign wr_acc = bus.wr_en & (~full_q | rd_acc);

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_nxt = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;   // wraps by natural overflow
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_nxt;
         // Flags come from the next count, so they match count after the edge.
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == DEPTH_C);
         afull_q <= (count_nxt >= AFULL_C);
         // A new error event takes priority over a clear in the same cycle.
         if (bus.wr_en & ~wr_acc) overrun_q  <= 1'b1;
         else if (bus.clr_err)    overrun_q  <= 1'b0;
         if (bus.rd_en & empty_q) underrun_q <= 1'b1;
         else if (bus.clr_err)    underrun_q <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset. Reset returns the pointers to 0,
   // which discards the contents, and this lets the array map to RAM.
   always_ff @(posedge clk_r) begin
      if (wr_acc) mem[wr_ptr] <= bus.wr_data;
   end

`ifdef UART_RX_FIFO_FWFT_EN
   // The head word is shown combinationally from the array.
   assign bus.rd_data  = mem[rd_ptr];
   assign bus.rd_valid = ~empty_q;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   // rd_data keeps the last popped word. rd_valid marks the cycle after a pop.
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.empty       = empty_q;
   assign bus.full        = full_q;
   assign bus.almost_full = afull_q;
   assign bus.count       = count_q;
   assign bus.overrun     = overrun_q;
   assign bus.underrun    = underrun_q;

endmodule
